// File: rtl/pwm_duty_capture.sv
// PWM duty/period capture: synchronises and deglitches a PWM input, measures high time and
// period of every PWM cycle in clk cycles, and presents each result on a valid/ready register.
module pwm_duty_capture #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             pwm_in_data_i,
    input  logic             sample_ready_i,
    output logic             sample_valid_o,
    output logic [CNT_W-1:0] high_cnt_o,
    output logic [CNT_W-1:0] period_cnt_o,
    output logic             timeout_o,
    output logic             overrun_o
);

    localparam int                FCNT_W    = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [FCNT_W-1:0] FILT_LAST = FCNT_W'(FILT_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   synced_p0;
    logic [FCNT_W-1:0]      filt_cnt_p1;
    logic                   filt_p1;
    logic                   filt_p2;
    logic                   rise_p2;
    logic                   fall_p2;

    state_t                 state;
    logic [CNT_W-1:0]       hi_cnt;
    logic [CNT_W-1:0]       per_cnt;

    logic                   done_p2;
    logic [CNT_W-1:0]       done_hi_p2;
    logic [CNT_W-1:0]       done_per_p2;
    logic                   done_to_p2;

    // ---- stage 0: metastability synchroniser ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_p0 <= '0;
        end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], pwm_in_data_i};
        end
    end

    assign synced_p0 = sync_p0[SYNC_STAGES-1];

    // ---- stage 1: deglitch filter ----
    // The level only moves after FILT_LEN disagreeing samples in a row, so every edge is
    // delayed by the same amount and measured widths match the input widths.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_cnt_p1 <= '0;
            filt_p1     <= 1'b0;
            filt_p2     <= 1'b0;
        end else begin
            filt_p2 <= filt_p1;
            if (synced_p0 != filt_p1) begin
                if (filt_cnt_p1 == FILT_LAST) begin
                    filt_p1     <= synced_p0;
                    filt_cnt_p1 <= '0;
                end else begin
                    filt_cnt_p1 <= filt_cnt_p1 + FCNT_W'(1);
                end
            end else begin
                filt_cnt_p1 <= '0;
            end
        end
    end

    // ---- stage 2: edge detect and measurement FSM ----
    assign rise_p2 = filt_p1 & ~filt_p2;
    assign fall_p2 = ~filt_p1 & filt_p2;

    always_comb begin
        done_p2     = 1'b0;
        done_hi_p2  = hi_cnt;
        done_per_p2 = per_cnt;
        done_to_p2  = 1'b0;
        if (state == HIGH || state == LOW) begin
            if (rise_p2) begin
                done_p2 = 1'b1;
            end else if (per_cnt == CNT_MAX) begin
                done_p2     = 1'b1;
                done_per_p2 = CNT_MAX;
                done_to_p2  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            hi_cnt  <= '0;
            per_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rise_p2) begin
                        state   <= HIGH;
                        hi_cnt  <= CNT_ONE;
                        per_cnt <= CNT_ONE;
                    end else begin
                        hi_cnt  <= '0;
                        per_cnt <= '0;
                    end
                end
                HIGH, LOW: begin
                    if (rise_p2) begin
                        // Rising edge closes one period and opens the next in the same cycle.
                        state   <= HIGH;
                        hi_cnt  <= CNT_ONE;
                        per_cnt <= CNT_ONE;
                    end else if (per_cnt == CNT_MAX) begin
                        state   <= IDLE;
                        hi_cnt  <= '0;
                        per_cnt <= '0;
                    end else begin
                        per_cnt <= sat_inc(per_cnt);
                        if (state == HIGH) begin
                            if (fall_p2) begin
                                state <= LOW;
                            end else begin
                                hi_cnt <= sat_inc(hi_cnt);
                            end
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    hi_cnt  <= '0;
                    per_cnt <= '0;
                end
            endcase
        end
    end

    // ---- stage 3: result register with valid/ready handshake ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sample_valid_o <= 1'b0;
            high_cnt_o     <= '0;
            period_cnt_o   <= '0;
            timeout_o      <= 1'b0;
            overrun_o      <= 1'b0;
        end else begin
            overrun_o <= 1'b0;
            if (done_p2) begin
                if (!sample_valid_o || sample_ready_i) begin
                    sample_valid_o <= 1'b1;
                    high_cnt_o     <= done_hi_p2;
                    period_cnt_o   <= done_per_p2;
                    timeout_o      <= done_to_p2;
                end else begin
                    overrun_o <= 1'b1;
                end
            end else if (sample_valid_o && sample_ready_i) begin
                sample_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pwm_duty_capture.sv
// Directed plus randomized bench for pwm_duty_capture; expected measurements come from an
// edge-time model of the input waveform (constant filter delay, short pulses rejected).
module tb_pwm_duty_capture;

    localparam int CNT_W = 10;
    localparam int SYNC  = 2;
    localparam int FILT  = 3;
    localparam int MAXV  = (1 << CNT_W) - 1;
    localparam int LAT   = SYNC + FILT;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             pwm = 1'b0;
    logic             ready = 1'b0;
    logic             sample_valid_o;
    logic [CNT_W-1:0] high_cnt_o;
    logic [CNT_W-1:0] period_cnt_o;
    logic             timeout_o;
    logic             overrun_o;

    pwm_duty_capture #(
        .CNT_W      (CNT_W),
        .SYNC_STAGES(SYNC),
        .FILT_LEN   (FILT)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .pwm_in_data_i (pwm),
        .sample_ready_i(ready),
        .sample_valid_o(sample_valid_o),
        .high_cnt_o    (high_cnt_o),
        .period_cnt_o  (period_cnt_o),
        .timeout_o     (timeout_o),
        .overrun_o     (overrun_o)
    );

    always #10 clk = ~clk;

    typedef struct {
        int hi;
        int per;
        bit to;
    } meas_t;

    meas_t exp_q[$];
    meas_t got_q[$];
    int    got_idx  = 0;
    int    n_cmp    = 0;
    int    n_bad    = 0;
    int    ovr_cnt  = 0;
    int    now_t    = 0;
    bit    m_lvl    = 1'b0;
    bit    m_active = 1'b0;
    bit    m_fell   = 1'b0;
    int    m_rise   = 0;
    int    m_fall   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_cmp++;
        assert (obs === req) else begin
            n_bad++;
            $error("FAIL %s: observed %0d, required %0d", tag, obs, req);
        end
    endtask

    function automatic void push_exp(input int hi, input int per, input bit to);
        meas_t m;
        m.hi  = hi;
        m.per = per;
        m.to  = to;
        exp_q.push_back(m);
    endfunction

    // A period that has lasted beyond the counter range ends as a timeout sample.
    function automatic void model_timeout();
        int hi;
        if (m_active && (now_t - m_rise) > MAXV) begin
            hi = (m_fell && (m_fall - m_rise) < MAXV) ? (m_fall - m_rise) : MAXV;
            push_exp(hi, MAXV, 1'b1);
            m_active = 1'b0;
        end
    endfunction

    function automatic void model_edge(input bit lvl, input int len);
        if (lvl != m_lvl && len >= FILT) begin
            model_timeout();
            m_lvl = lvl;
            if (lvl) begin
                if (m_active) push_exp(m_fall - m_rise, now_t - m_rise, 1'b0);
                m_active = 1'b1;
                m_rise   = now_t;
                m_fell   = 1'b0;
            end else if (m_active) begin
                m_fell = 1'b1;
                m_fall = now_t;
            end
        end
    endfunction

    task automatic compare_pending();
        meas_t g;
        meas_t e;
        while (got_idx < got_q.size()) begin
            g = got_q[got_idx];
            got_idx++;
            n_cmp++;
            assert (exp_q.size() > 0) else begin
                n_bad++;
                $error("FAIL unexpected_sample: observed high=%0d period=%0d, required none pending",
                       g.hi, g.per);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sample_high", g.hi, e.hi);
                check("sample_period", g.per, e.per);
                check("sample_timeout", 32'(g.to), 32'(e.to));
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        now_t++;
        model_timeout();
        compare_pending();
    endtask

    task automatic seg(input bit lvl, input int len);
        model_edge(lvl, len);
        pwm = lvl;
        repeat (len) step();
    endtask

    // Occasionally splits a segment with a glitch too short to pass the filter.
    task automatic seg_g(input bit lvl, input int len);
        int g;
        int a;
        if (len >= 3 * FILT && $urandom_range(0, 2) == 0) begin
            g = $urandom_range(1, FILT - 1);
            a = $urandom_range(FILT, len - g - FILT);
            seg(lvl, a);
            seg(!lvl, g);
            seg(lvl, len - g - a);
        end else begin
            seg(lvl, len);
        end
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            step();
            k++;
        end
        check("drain_pending", exp_q.size(), 0);
    endtask

    task automatic check_held(input string tag, input int v, input int hi, input int per, input int to);
        check({tag, "_valid"}, 32'(sample_valid_o), v);
        check({tag, "_high"}, 32'(high_cnt_o), hi);
        check({tag, "_period"}, 32'(period_cnt_o), per);
        check({tag, "_timeout"}, 32'(timeout_o), to);
    endtask

    always @(negedge clk) begin
        meas_t m;
        if (overrun_o) ovr_cnt++;
        if (reset_n && sample_valid_o && ready) begin
            m.hi  = int'(high_cnt_o);
            m.per = int'(period_cnt_o);
            m.to  = timeout_o;
            got_q.push_back(m);
        end
    end

    initial begin
        #(20 * 60000);
        $display("FAIL watchdog: simulation exceeded its cycle budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ovr0;
        int acc0;
        int lo_len;
        int hi_len;

        // Reset state
        reset_n = 1'b0;
        pwm     = 1'b0;
        ready   = 1'b1;
        repeat (3) step();
        check_held("reset", 0, 0, 0, 0);
        check("reset_overrun", 32'(overrun_o), 0);
        reset_n = 1'b1;

        // Nominal 25/125 waveform after a short lead-in pulse
        seg(1'b1, 5);
        repeat (40) begin
            seg(1'b0, 100);
            seg(1'b1, 25);
        end
        drain(50);
        check("nominal_count", got_q.size(), 40);
        check_held("nominal_last", 0, 25, 125, 0);
        check("nominal_overrun", ovr_cnt, 0);

        // Deglitch: 2-cycle low is swallowed, 3-cycle low splits the period
        seg(1'b0, 100);
        seg(1'b1, 10);
        seg(1'b0, 2);
        seg(1'b1, 13);
        seg(1'b0, 100);
        seg(1'b1, 10);
        seg(1'b0, 3);
        seg(1'b1, 12);
        seg(1'b0, 100);
        seg(1'b1, 25);
        seg(1'b0, 100);
        seg(1'b1, 25);
        drain(50);
        check_held("deglitch_last", 0, 25, 125, 0);

        // Randomized periods with occasional sub-filter glitches
        repeat (30) begin
            lo_len = $urandom_range(FILT, 200);
            hi_len = $urandom_range(FILT, 60);
            seg_g(1'b0, lo_len);
            seg_g(1'b1, hi_len);
        end
        drain(50);
        check("random_overrun", ovr_cnt, 0);

        // Timeout after one valid period, then the partial period is not reported
        seg(1'b0, 100);
        seg(1'b1, 25);
        acc0 = got_q.size();
        seg(1'b0, MAXV + 50);
        drain(50);
        check("timeout_count", got_q.size() - acc0, 1);
        check_held("timeout", 0, 25, MAXV, 1);
        seg(1'b1, 25);
        seg(1'b0, 100);
        check("timeout_partial_count", got_q.size() - acc0, 1);
        seg(1'b1, 25);
        drain(50);
        check("timeout_recover_count", got_q.size() - acc0, 2);
        check_held("timeout_recover", 0, 25, 125, 0);

        // Back-pressure: first sample held, second dropped with one overrun pulse
        seg(1'b0, 100);
        ready = 1'b0;
        seg(1'b1, 25);
        check_held("bp_first", 1, 25, 125, 0);
        ovr0 = ovr_cnt;
        seg(1'b0, 60);
        seg(1'b1, 25);
        exp_q.delete(exp_q.size() - 1);
        check_held("bp_held", 1, 25, 125, 0);
        check("bp_overrun_pulses", ovr_cnt - ovr0, 1);
        check("bp_overrun_now", 32'(overrun_o), 0);
        ready = 1'b1;
        step();
        ready = 1'b0;
        check_held("bp_accept", 0, 25, 125, 0);

        // Accept and completion on the same edge
        seg(1'b0, 100);
        seg(1'b1, 25);
        check("sim_held_valid", 32'(sample_valid_o), 1);
        seg(1'b0, 100);
        model_edge(1'b1, 25);
        pwm = 1'b1;
        repeat (LAT) step();
        ready = 1'b1;
        ovr0 = ovr_cnt;
        step();
        check_held("sim_reload", 1, 25, 125, 0);
        check("sim_overrun_now", 32'(overrun_o), 0);
        repeat (25 - LAT - 1) step();
        check("sim_overrun_pulses", ovr_cnt - ovr0, 0);
        check("sim_valid_after", 32'(sample_valid_o), 0);

        // Reset in the middle of a high phase while a sample is held
        seg(1'b0, 100);
        ready = 1'b0;
        seg(1'b1, 25);
        check("rst_held_valid", 32'(sample_valid_o), 1);
        seg(1'b0, 100);
        model_edge(1'b1, 25);
        pwm = 1'b1;
        repeat (10) step();
        reset_n = 1'b0;
        #1;
        check_held("rst_async", 0, 0, 0, 0);
        check("rst_async_overrun", 32'(overrun_o), 0);
        compare_pending();
        exp_q.delete();
        m_active = 1'b0;
        m_lvl    = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
        ready   = 1'b1;
        acc0    = got_q.size();
        seg(1'b1, 12);
        seg(1'b0, 100);
        check("rst_no_early_sample", got_q.size() - acc0, 0);
        seg(1'b1, 25);
        seg(1'b0, 100);
        seg(1'b1, 25);
        drain(50);
        check("rst_sample_count", got_q.size() - acc0, 2);
        check_held("rst_last", 0, 25, 125, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
